// File: rtl/jelly_rtos_pkg.sv
// Shared definitions for the RTOS event-flag unit: bus opcodes, status layout
// and the per-flag state encoding.
package jelly_rtos_pkg;

  localparam logic [7:0] OP_SET_FLG     = 8'h31;
  localparam logic [7:0] OP_CLR_FLG     = 8'h32;
  localparam logic [7:0] OP_WAI_FLG_AND = 8'h33;
  localparam logic [7:0] OP_WAI_FLG_OR  = 8'h34;
  localparam logic [7:0] OP_REF_FLG     = 8'h35;
  localparam logic [7:0] OP_REF_STS     = 8'h36;
  localparam logic [7:0] OP_CAN_WAI     = 8'h37;

  localparam int STS_ERR_BIT   = 8;
  localparam int STS_STATE_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    REL  = 2'd2
  } flg_state_t;

  // Packs one flag's status word as returned by REF_STS.
  function automatic logic [15:0] make_sts(input logic err, input flg_state_t st);
    logic [15:0] v;
    v = '0;
    v[STS_ERR_BIT] = err;
    v[STS_STATE_LSB +: 2] = st;
    return v;
  endfunction

endpackage

// File: rtl/jelly_rtos_eventflag_unit.sv
// One event flag: its pattern, wait pattern/mode, waiting task id, state and
// sticky error bit.
module jelly_rtos_eventflag_unit
  import jelly_rtos_pkg::*;
#(
  parameter int FLGPTN_WIDTH = 32,
  parameter int TSKID_WIDTH  = 4,
  parameter bit CLR_ON_REL   = 1'b0
)
(
  input  logic                    wb_rst_i,
  input  logic                    wb_clk_i,
  input  logic                    i_set,
  input  logic                    i_clr,
  input  logic                    i_wai,
  input  logic                    i_wai_or,
  input  logic                    i_can,
  input  logic                    i_sts_rd,
  input  logic                    i_done,
  input  logic [FLGPTN_WIDTH-1:0] i_dat,
  input  logic [TSKID_WIDTH-1:0]  i_tskid,
  output logic [FLGPTN_WIDTH-1:0] o_ptn,
  output flg_state_t              o_state,
  output logic                    o_err,
  output logic [TSKID_WIDTH-1:0]  o_tskid
);

  logic [FLGPTN_WIDTH-1:0] r_ptn;
  logic [FLGPTN_WIDTH-1:0] r_wptn;
  logic                    r_or;
  logic [TSKID_WIDTH-1:0]  r_tskid;
  flg_state_t              r_state;
  logic                    r_err;
  logic                    w_hit;
  logic                    w_release;

  assign w_hit     = r_or ? (|(r_ptn & r_wptn)) : ((r_ptn & r_wptn) == r_wptn);
  assign w_release = (r_state == WAIT) && w_hit;

  // The release condition uses the registered pattern, so a write landing on
  // the release edge is seen one cycle later; a clear-on-release beats it.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_ptn   <= '0;
      r_wptn  <= '0;
      r_or    <= 1'b0;
      r_tskid <= '0;
      r_state <= IDLE;
      r_err   <= 1'b0;
    end else begin
      if (w_release && CLR_ON_REL) begin
        r_ptn <= '0;
      end else if (i_set) begin
        r_ptn <= r_ptn | i_dat;
      end else if (i_clr) begin
        r_ptn <= r_ptn & i_dat;
      end

      if (i_sts_rd) begin
        r_err <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (i_wai) begin
            if (i_dat == '0) begin
              r_err <= 1'b1;
            end else begin
              r_state <= WAIT;
              r_wptn  <= i_dat;
              r_or    <= i_wai_or;
              r_tskid <= i_tskid;
            end
          end
        end
        WAIT: begin
          if (i_wai) begin
            r_err <= 1'b1;
          end
          if (w_hit) begin
            r_state <= REL;
          end else if (i_can) begin
            r_state <= IDLE;
          end
        end
        REL: begin
          if (i_wai) begin
            r_err <= 1'b1;
          end
          if (i_done) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ptn   = r_ptn;
  assign o_state = r_state;
  assign o_err   = r_err;
  assign o_tskid = r_tskid;

endmodule

// File: rtl/jelly_rtos_eventflag.sv
// Multi-flag event-flag block on the Wishbone slave bus: address decode, read
// mux and a fixed-priority wake-request arbiter toward the scheduler.
module jelly_rtos_eventflag
  import jelly_rtos_pkg::*;
#(
  parameter int               WB_ADR_WIDTH = 16,
  parameter int               WB_DAT_WIDTH = 32,
  parameter int               FLGPTN_WIDTH = 32,
  parameter int               FLG_NUM      = 4,
  parameter int               TSKID_WIDTH  = 4,
  parameter logic [FLG_NUM-1:0] CLR_ON_REL = '0
)
(
  input  logic                      wb_rst_i,
  input  logic                      wb_clk_i,
  input  logic [WB_ADR_WIDTH-1:0]   s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0]   s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0]   s_wb_dat_o,
  input  logic                      s_wb_we_i,
  input  logic [WB_DAT_WIDTH/8-1:0] s_wb_sel_i,
  input  logic                      s_wb_stb_i,
  output logic                      s_wb_ack_o,
  input  logic [TSKID_WIDTH-1:0]    run_tskid,
  output logic                      wup_valid,
  output logic [TSKID_WIDTH-1:0]    wup_tskid,
  input  logic                      wup_ready
);

  logic                    r_ack;
  logic [WB_DAT_WIDTH-1:0] r_dat;
  logic                    r_valid;
  logic [TSKID_WIDTH-1:0]  r_tskid;
  logic [FLG_NUM-1:0]      r_gnt;

  logic                    w_access;
  logic                    w_rd;
  logic [7:0]              w_op;
  logic [7:0]              w_id;
  logic [FLGPTN_WIDTH-1:0] w_dat;
  logic [WB_DAT_WIDTH-1:0] w_rdata;
  logic                    w_done;
  logic                    w_found;
  logic [FLG_NUM-1:0]      w_pick;
  logic [TSKID_WIDTH-1:0]  w_pick_tskid;
  logic [FLG_NUM-1:0]      w_rel;
  logic [FLG_NUM-1:0]      w_err;
  logic [FLGPTN_WIDTH-1:0] w_ptn   [FLG_NUM];
  flg_state_t              w_state [FLG_NUM];
  logic [TSKID_WIDTH-1:0]  w_tskid [FLG_NUM];
  logic                    w_unused;

  assign w_unused = ^s_wb_sel_i;
  assign w_access = s_wb_stb_i & ~r_ack;
  assign w_rd     = w_access & ~s_wb_we_i;
  assign w_op     = s_wb_adr_i[15:8];
  assign w_id     = s_wb_adr_i[7:0];
  assign w_dat    = s_wb_dat_i[FLGPTN_WIDTH-1:0];
  assign w_done   = r_valid & wup_ready;

  for (genvar g = 0; g < FLG_NUM; g++) begin : g_flag
    logic w_sel;
    assign w_sel    = w_access && (w_id == 8'(g));
    assign w_rel[g] = (w_state[g] == REL);

    jelly_rtos_eventflag_unit #(
      .FLGPTN_WIDTH (FLGPTN_WIDTH),
      .TSKID_WIDTH  (TSKID_WIDTH),
      .CLR_ON_REL   (CLR_ON_REL[g])
    ) u_unit (
      .wb_rst_i (wb_rst_i),
      .wb_clk_i (wb_clk_i),
      .i_set    (w_sel & s_wb_we_i & (w_op == OP_SET_FLG)),
      .i_clr    (w_sel & s_wb_we_i & (w_op == OP_CLR_FLG)),
      .i_wai    (w_sel & s_wb_we_i & ((w_op == OP_WAI_FLG_AND) | (w_op == OP_WAI_FLG_OR))),
      .i_wai_or (w_op == OP_WAI_FLG_OR),
      .i_can    (w_sel & s_wb_we_i & (w_op == OP_CAN_WAI)),
      .i_sts_rd (w_sel & ~s_wb_we_i & (w_op == OP_REF_STS)),
      .i_done   (w_done & r_gnt[g]),
      .i_dat    (w_dat),
      .i_tskid  (run_tskid),
      .o_ptn    (w_ptn[g]),
      .o_state  (w_state[g]),
      .o_err    (w_err[g]),
      .o_tskid  (w_tskid[g])
    );
  end

  always_comb begin
    w_rdata = '0;
    for (int n = 0; n < FLG_NUM; n++) begin
      if (w_id == 8'(n)) begin
        if (w_op == OP_REF_FLG) begin
          w_rdata = WB_DAT_WIDTH'(w_ptn[n]);
        end else if (w_op == OP_REF_STS) begin
          w_rdata = WB_DAT_WIDTH'(make_sts(w_err[n], w_state[n]));
        end
      end
    end
  end

  // Lowest released flag wins; the flag currently being granted is excluded so
  // the next grant can be loaded on the very edge its handshake completes.
  always_comb begin
    w_pick       = '0;
    w_pick_tskid = '0;
    w_found      = 1'b0;
    for (int n = FLG_NUM - 1; n >= 0; n--) begin
      if (w_rel[n] && !r_gnt[n]) begin
        w_pick       = '0;
        w_pick[n]    = 1'b1;
        w_pick_tskid = w_tskid[n];
        w_found      = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_access;
      r_dat <= w_rd ? w_rdata : '0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_valid <= 1'b0;
      r_tskid <= '0;
      r_gnt   <= '0;
    end else if (!r_valid || w_done) begin
      r_valid <= w_found;
      r_tskid <= w_pick_tskid;
      r_gnt   <= w_pick;
    end
  end

  assign s_wb_ack_o = r_ack;
  assign s_wb_dat_o = r_dat;
  assign wup_valid  = r_valid;
  assign wup_tskid  = r_tskid;

endmodule

// File: tb/tb_jelly_rtos_eventflag.sv
// Directed bench for jelly_rtos_eventflag: four flags, flag 1 clears on release.
module tb_jelly_rtos_eventflag;
  import jelly_rtos_pkg::*;

  logic        wb_rst_i;
  logic        wb_clk_i;
  logic [15:0] s_wb_adr_i;
  logic [31:0] s_wb_dat_i;
  logic [31:0] s_wb_dat_o;
  logic        s_wb_we_i;
  logic [3:0]  s_wb_sel_i;
  logic        s_wb_stb_i;
  logic        s_wb_ack_o;
  logic [3:0]  run_tskid;
  logic        wup_valid;
  logic [3:0]  wup_tskid;
  logic        wup_ready;

  int total = 0;
  int bad   = 0;
  logic [31:0] rd;

  jelly_rtos_eventflag #(
    .WB_ADR_WIDTH (16),
    .WB_DAT_WIDTH (32),
    .FLGPTN_WIDTH (32),
    .FLG_NUM      (4),
    .TSKID_WIDTH  (4),
    .CLR_ON_REL   (4'b0010)
  ) dut (
    .wb_rst_i   (wb_rst_i),
    .wb_clk_i   (wb_clk_i),
    .s_wb_adr_i (s_wb_adr_i),
    .s_wb_dat_i (s_wb_dat_i),
    .s_wb_dat_o (s_wb_dat_o),
    .s_wb_we_i  (s_wb_we_i),
    .s_wb_sel_i (s_wb_sel_i),
    .s_wb_stb_i (s_wb_stb_i),
    .s_wb_ack_o (s_wb_ack_o),
    .run_tskid  (run_tskid),
    .wup_valid  (wup_valid),
    .wup_tskid  (wup_tskid),
    .wup_ready  (wup_ready)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One Wishbone access; returns sampled read data just after the ack edge.
  task automatic applyStimulus(input logic [7:0] op, input logic [7:0] id,
                               input logic [31:0] dat, input logic we,
                               output logic [31:0] rdata);
    int n;
    @(negedge wb_clk_i);
    s_wb_adr_i = {op, id};
    s_wb_dat_i = dat;
    s_wb_we_i  = we;
    s_wb_stb_i = 1'b1;
    n = 0;
    do begin
      @(posedge wb_clk_i);
      #1;
      n++;
    end while (!s_wb_ack_o && n < 8);
    if (!s_wb_ack_o) checkOutput("ack_timeout", {31'b0, s_wb_ack_o}, 32'd1);
    rdata = s_wb_dat_o;
    s_wb_stb_i = 1'b0;
    s_wb_we_i  = 1'b0;
  endtask

  task automatic wbWrite(input logic [7:0] op, input logic [7:0] id, input logic [31:0] dat);
    logic [31:0] unusedData;
    applyStimulus(op, id, dat, 1'b1, unusedData);
  endtask

  task automatic readCheck(input string tag, input logic [7:0] op, input logic [7:0] id,
                           input logic [31:0] exp);
    logic [31:0] r;
    applyStimulus(op, id, 32'h0, 1'b0, r);
    checkOutput(tag, r, exp);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic checkWake(input string tag, input logic v, input logic [3:0] t);
    checkOutput({tag, "_valid"}, {31'b0, wup_valid}, {31'b0, v});
    if (v) checkOutput({tag, "_tskid"}, {28'b0, wup_tskid}, {28'b0, t});
  endtask

  initial begin
    wb_rst_i   = 1'b0;
    s_wb_adr_i = '0;
    s_wb_dat_i = '0;
    s_wb_we_i  = 1'b0;
    s_wb_sel_i = 4'hF;
    s_wb_stb_i = 1'b0;
    run_tskid  = '0;
    wup_ready  = 1'b0;

    // Reset values
    repeat (3) @(posedge wb_clk_i);
    #1;
    checkOutput("rst_ack", {31'b0, s_wb_ack_o}, 32'd0);
    checkOutput("rst_dat", s_wb_dat_o, 32'd0);
    checkOutput("rst_valid", {31'b0, wup_valid}, 32'd0);
    checkOutput("rst_tskid", {28'b0, wup_tskid}, 32'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;

    for (int i = 0; i < 4; i++) begin
      readCheck($sformatf("init_ref_flg%0d", i), OP_REF_FLG, 8'(i), 32'h0);
      readCheck($sformatf("init_ref_sts%0d", i), OP_REF_STS, 8'(i), 32'h0);
    end
    checkWake("init", 1'b0, 4'h0);

    // Flag 0: AND wait on 0x5, released after the second SET
    run_tskid = 4'd3;
    wbWrite(OP_WAI_FLG_AND, 8'd0, 32'h5);
    readCheck("f0_sts_wait", OP_REF_STS, 8'd0, 32'h1);
    wbWrite(OP_SET_FLG, 8'd0, 32'h1);
    waitCycles(2);
    checkWake("f0_partial", 1'b0, 4'h0);
    wbWrite(OP_SET_FLG, 8'd0, 32'h4);
    checkWake("f0_set_c0", 1'b0, 4'h0);
    waitCycles(1);
    checkWake("f0_set_c1", 1'b0, 4'h0);
    checkOutput("ack_pulse", {31'b0, s_wb_ack_o}, 32'd0);
    waitCycles(1);
    checkWake("f0_set_c2", 1'b1, 4'd3);
    wup_ready = 1'b1;
    waitCycles(1);
    wup_ready = 1'b0;
    checkWake("f0_done", 1'b0, 4'h0);
    readCheck("f0_sts_idle", OP_REF_STS, 8'd0, 32'h0);
    readCheck("f0_ptn_kept", OP_REF_FLG, 8'd0, 32'h5);
    readCheck("bad_opcode", 8'h30, 8'd0, 32'h0);
    readCheck("bad_id", OP_REF_FLG, 8'd4, 32'h0);

    // Flag 1: already-satisfied OR wait, clear on release
    wbWrite(OP_SET_FLG, 8'd1, 32'h8);
    wbWrite(OP_SET_FLG, 8'd4, 32'hFF);
    readCheck("f1_ptn", OP_REF_FLG, 8'd1, 32'h8);
    run_tskid = 4'd7;
    wbWrite(OP_WAI_FLG_OR, 8'd1, 32'hC);
    waitCycles(2);
    checkWake("f1_wake", 1'b1, 4'd7);
    wup_ready = 1'b1;
    waitCycles(1);
    wup_ready = 1'b0;
    checkWake("f1_done", 1'b0, 4'h0);
    readCheck("f1_ptn_cleared", OP_REF_FLG, 8'd1, 32'h0);
    readCheck("f1_sts_idle", OP_REF_STS, 8'd1, 32'h0);

    // Flags 0 and 2 both released while flag 3 holds the grant
    wbWrite(OP_CLR_FLG, 8'd0, 32'h0);
    readCheck("f0_clr", OP_REF_FLG, 8'd0, 32'h0);
    run_tskid = 4'd9;
    wbWrite(OP_WAI_FLG_AND, 8'd0, 32'h1);
    run_tskid = 4'hA;
    wbWrite(OP_WAI_FLG_OR, 8'd2, 32'h2);
    wbWrite(OP_SET_FLG, 8'd3, 32'h1);
    run_tskid = 4'hB;
    wbWrite(OP_WAI_FLG_OR, 8'd3, 32'h1);
    wbWrite(OP_SET_FLG, 8'd2, 32'h2);
    wbWrite(OP_SET_FLG, 8'd0, 32'h1);
    waitCycles(2);
    checkWake("blocker", 1'b1, 4'hB);
    wup_ready = 1'b1;
    waitCycles(1);
    wup_ready = 1'b0;
    checkWake("prio_f0", 1'b1, 4'd9);
    for (int i = 0; i < 5; i++) begin
      waitCycles(1);
      checkWake($sformatf("hold_f0_%0d", i), 1'b1, 4'd9);
    end
    wup_ready = 1'b1;
    waitCycles(1);
    checkWake("next_f2", 1'b1, 4'hA);
    waitCycles(1);
    wup_ready = 1'b0;
    checkWake("all_done", 1'b0, 4'h0);
    readCheck("f2_sts_idle", OP_REF_STS, 8'd2, 32'h0);

    // Error handling and cancel on flag 3
    run_tskid = 4'hC;
    wbWrite(OP_WAI_FLG_AND, 8'd3, 32'h2);
    wbWrite(OP_WAI_FLG_AND, 8'd3, 32'h2);
    wbWrite(OP_WAI_FLG_OR, 8'd3, 32'h0);
    readCheck("f3_sts_err", OP_REF_STS, 8'd3, 32'h101);
    readCheck("f3_sts_clr", OP_REF_STS, 8'd3, 32'h001);
    wbWrite(OP_CAN_WAI, 8'd3, 32'h0);
    waitCycles(3);
    checkWake("f3_cancel", 1'b0, 4'h0);
    readCheck("f3_sts_idle", OP_REF_STS, 8'd3, 32'h0);
    wbWrite(OP_WAI_FLG_AND, 8'd2, 32'h0);
    readCheck("f2_zero_wait", OP_REF_STS, 8'd2, 32'h100);

    // Reset during a pending wake and an in-flight bus cycle
    run_tskid = 4'd5;
    wbWrite(OP_WAI_FLG_AND, 8'd0, 32'h1);
    waitCycles(2);
    checkWake("pre_reset", 1'b1, 4'd5);
    @(negedge wb_clk_i);
    s_wb_adr_i = {OP_REF_FLG, 8'd0};
    s_wb_we_i  = 1'b0;
    s_wb_stb_i = 1'b1;
    @(posedge wb_clk_i);
    #1;
    checkOutput("pre_reset_ack", {31'b0, s_wb_ack_o}, 32'd1);
    wb_rst_i = 1'b0;
    #1;
    checkOutput("mid_rst_ack", {31'b0, s_wb_ack_o}, 32'd0);
    checkOutput("mid_rst_dat", s_wb_dat_o, 32'd0);
    checkOutput("mid_rst_valid", {31'b0, wup_valid}, 32'd0);
    checkOutput("mid_rst_tskid", {28'b0, wup_tskid}, 32'd0);
    s_wb_stb_i = 1'b0;
    waitCycles(2);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      readCheck($sformatf("post_rst_flg%0d", i), OP_REF_FLG, 8'(i), 32'h0);
      readCheck($sformatf("post_rst_sts%0d", i), OP_REF_STS, 8'(i), 32'h0);
    end
    waitCycles(3);
    checkWake("post_rst", 1'b0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jelly_rtos_eventflag.md
# jelly_rtos_eventflag

Parametrised event-flag unit for the RTOS hardware core, sitting on the core's Wishbone slave bus beside the task scheduler. It provides `FLG_NUM` independent event flags of `FLGPTN_WIDTH` bits each, with AND- and OR-wait modes and optional clear-on-release. It emits task wake-up requests toward the scheduler through a valid/ready handshake. It replaces the single fixed-width flag by adding multiple flags, error status and back-pressure on wake requests.

## Interface
Parameters:
- WB_ADR_WIDTH, 16, Wishbone address width; opcode in bits [15:8], flag id in bits [7:0]
- WB_DAT_WIDTH, 32, Wishbone data width
- FLGPTN_WIDTH, 32, flag pattern width; must be ≤ WB_DAT_WIDTH
- FLG_NUM, 4, number of flags (1..256)
- TSKID_WIDTH, 4, task id width
- CLR_ON_REL, '0, FLG_NUM-bit mask; bit n=1 clears flag n's pattern to 0 on release

Ports:
- wb_rst_i  in  1  asynchronous reset, active-low
- wb_clk_i  in  1  clock
- s_wb_adr_i  in  WB_ADR_WIDTH  address
- s_wb_dat_i  in  WB_DAT_WIDTH  write data
- s_wb_dat_o  out  WB_DAT_WIDTH  read data
- s_wb_we_i  in  1  write enable
- s_wb_sel_i  in  WB_DAT_WIDTH/8  byte select; ignored, full-word access only
- s_wb_stb_i  in  1  strobe
- s_wb_ack_o  out  1  acknowledge
- run_tskid  in  TSKID_WIDTH  id of the currently running task; latched as the waiter on WAI_FLG
- wup_valid  out  1  wake request valid
- wup_tskid  out  TSKID_WIDTH  task to wake
- wup_ready  in  1  scheduler accepts the wake request

## Operation
- Opcodes (addr[15:8]): 0x31 SET_FLG (ptn |= dat), 0x32 CLR_FLG (ptn &= dat), 0x33 WAI_FLG_AND, 0x34 WAI_FLG_OR (wait pattern = dat), 0x35 REF_FLG (read ptn), 0x36 REF_STS (read status), 0x37 CAN_WAI (cancel wait). Any other opcode: write ignored, read returns 0. Read/write are acked.
- Addresses with id ≥ FLG_NUM: write ignored, read returns 0, ack still given.
- Per-flag state machine: IDLE → WAIT on WAI_FLG_*; WAIT → REL when the condition holds (AND: (ptn & wptn) == wptn; OR: (ptn & wptn) != 0); REL → IDLE on wake handshake; WAIT → IDLE on CAN_WAI (no wake is issued).
- WAI_FLG in WAIT or REL, or with wptn == 0: request ignored, sticky err bit set. REF_STS reads {err[8], state[1:0]}; a read of REF_STS clears err.
- On WAIT→REL, if CLR_ON_REL[n]=1 then ptn is cleared to 0 on the same edge.
- Wake arbiter: the lowest-index flag in REL wins. wup_valid and wup_tskid are registered and held stable until wup_ready. Index search starts from 0 each grant; there is no round-robin.
- Data is zero-extended/truncated to FLGPTN_WIDTH.

## Timing
- Reset: s_wb_ack_o=0, s_wb_dat_o=0, wup_valid=0, wup_tskid=0, every ptn=0, every state=IDLE, every err=0, every waiter id=0.
- Wishbone: ack = stb & ~ack, registered, so a single-cycle ack pulse follows one cycle after stb. The master holds stb until it sees ack. The write takes effect on the edge that raises ack. Read data is registered with ack.
- Condition evaluation uses registered ptn/wptn. WAIT→REL occurs 1 cycle after the write making the condition true. A WAI_FLG whose condition is already satisfied reaches REL 1 cycle after its ack edge.
- wup_valid rises 1 cycle after REL is entered, provided no other grant is pending. Handshake completes on an edge with valid & ready. The next grant's valid can rise on the following edge, so there are no bubbles on back-to-back releases.
- SET_FLG and release on the same edge: the release sees the pre-write ptn. A CLR_ON_REL clear takes priority over a simultaneous SET/CLR write.
- CAN_WAI while the flag is in REL with its grant presented: the grant completes and the cancel is ignored.
- Reset asserted mid-transaction or mid-handshake: everything returns immediately to reset values and no wake is retained.

## Structure
- Package jelly_rtos_pkg: opcode constants, REF_STS bit positions, flg_state_t enum {IDLE, WAIT, REL}.
- Sub-module jelly_rtos_eventflag_unit: one flag's ptn, wptn, mode, waiter id, state and err. Generate FLG_NUM instances; the top holds the Wishbone decode, the read mux and the priority wake arbiter.

## Test plan
- Reset, then REF_FLG/REF_STS on every id → all 0; wup_valid=0 throughout.
- Flag 0: WAI_FLG_AND dat=5 with run_tskid=3; SET 1 → no wake; SET 4 → wup_valid with tskid=3 exactly 2 cycles after the SET ack; ready=1 → state IDLE.
- Flag 1, CLR_ON_REL[1]=1: ptn=0x8, WAI_FLG_OR 0xC → immediate REL, wake issued, REF_FLG afterwards = 0.
- Flags 0 and 2 released on the same edge, wup_ready=0 for 5 cycles → flag 0's tskid held stable; after ready, flag 2's tskid on the next cycle.
- WAI_FLG twice on flag 3, and WAI_FLG with dat=0 → REF_STS err=1 with state WAIT; a second REF_STS read → err=0. CAN_WAI → IDLE and no wake.
- Assert wb_rst_i low while wup_valid=1 and a stb is outstanding → wup_valid=0, s_wb_ack_o=0 and all patterns 0 immediately.
